// File: rtl/seq_divider_nr.sv
// Sequential unsigned non-restoring divider, one add/sub step per clock.
// Start/busy/done handshake; results held until the next FIX edge.
module seq_divider_nr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]    r_state;
    logic [W:0]    r_p;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_d;
    logic [CW-1:0] r_cnt;
    logic          r_zero;
    logic          r_done;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic          r_dz;

    logic [W:0]    w_shift;
    logic [W:0]    w_pnew;
    logic [W-1:0]  w_rfix;
    logic          w_last;

    // Partial remainder shifted by one dividend bit
    assign w_shift = {r_p[W-1:0], r_q[W-1]};

    // Add or subtract the divisor depending on the sign of P
    assign w_pnew = r_p[W] ? (w_shift + {1'b0, r_d})
                           : (w_shift - {1'b0, r_d});

    // Final correction; the true remainder fits in W bits
    assign w_rfix = r_p[W] ? (r_p[W-1:0] + r_d) : r_p[W-1:0];

    assign w_last = (r_cnt == CW'(W - 1));

    // Control FSM and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_d     <= divisor;
                        r_q     <= dividend;
                        r_p     <= '0;
                        r_cnt   <= '0;
                        r_zero  <= (divisor == '0);
                        r_state <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    r_p   <= w_pnew;
                    r_q   <= {r_q[W-2:0], ~w_pnew[W]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result registers, loaded only on the FIX edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (r_state == FIX) begin
                if (r_zero) begin
                    r_quo <= '1;
                    r_rem <= r_q;
                    r_dz  <= 1'b1;
                end else begin
                    r_quo <= r_q;
                    r_rem <= w_rfix;
                    r_dz  <= 1'b0;
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider_nr.sv
// Directed-vector and random bench for seq_divider_nr (W=8).
// Expected results are hand-computed or taken from / and %.
module tb_seq_divider_nr;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_chk;
    int n_fail;

    seq_divider_nr #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller must be mid-cycle with busy low. Returns #1 after the done edge.
    task automatic run_op(input string name,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input bit full);
        int lat;
        int bcnt;
        int elat;
        elat     = (b == 0) ? 1 : W + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, lat, elat);
        chk({name, " quotient"}, int'(quotient), int'(eq));
        chk({name, " remainder"}, int'(remainder), int'(er));
        chk({name, " div_by_zero"}, int'(div_by_zero), int'(edz));
        if (full) begin
            chk({name, " busy cycles"}, bcnt, elat);
            chk({name, " busy at done"}, int'(busy), 0);
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rq;
        logic [W-1:0] rr;

        n_chk  = 0;
        n_fail = 0;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[4]  = '{8'd77,  8'd0,   8'hFF,  8'd77,  1'b1};
        vecs[5]  = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[7]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
        vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
        vecs[9]  = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};
        vecs[10] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};
        vecs[11] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
        vecs[12] = '{8'd99,  8'd10,  8'd9,   8'd9,   1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #23;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset dz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done pulse width", i), int'(done), 0);
        end

        // start pulses while busy must be ignored
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            if (lat == 2 || lat == 4) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("ignore latency", lat, W + 1);
        chk("ignore quotient", int'(quotient), 15);
        chk("ignore remainder", int'(remainder), 5);
        @(posedge clk);
        #1;
        chk("ignore no restart", int'(busy), 0);

        // reset mid-divide clears everything, no done pulse
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort quotient", int'(quotient), 0);
        chk("abort remainder", int'(remainder), 0);
        chk("abort dz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        chk("abort no done", lat, 0);
        run_op("after abort", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // back-to-back: second start in the done cycle
        run_op("b2b first", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
        run_op("b2b second", 8'd99, 8'd10, 8'd9, 8'd9, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // random operands against the language operators
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = (i % 50 == 0) ? '0 : W'($urandom_range(0, 255));
            if (rb == 0) begin
                rq = '1;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_op($sformatf("rand %0d/%0d", ra, rb), ra, rb, rq, rr,
                   (rb == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
